// File: rtl/memory_data_sized_pkg.sv
// Shared definitions for the sized data memory: access-size codes,
// the unsigned-load bit position and the clear/ready state encodings.
package memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // Bit of the size code that requests zero extension on byte/half loads
  localparam int SIZE_UNSIGNED_BIT = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_data_sized_if.sv
// MEM-stage bus of the sized data memory: load/store request, debug read
// and the registered load result / status flags.
interface memory_data_sized_if #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3
);

  logic                    i_step;
  logic [NB-1:0]           i_alu_address;
  logic [NB-1:0]           i_data_to_write;
  logic                    i_mem_write;
  logic                    i_mem_read;
  logic [NB_SIZE_TYPE-1:0] i_size_type;
  logic [NB-1:0]           i_debug_address;
  logic [NB-1:0]           o_alu_address_data;
  logic [NB-1:0]           o_debug_address_data;
  logic                    o_misaligned;
  logic                    o_busy;

  modport master (
    output i_step, i_alu_address, i_data_to_write, i_mem_write, i_mem_read,
           i_size_type, i_debug_address,
    input  o_alu_address_data, o_debug_address_data, o_misaligned, o_busy
  );

  modport slave (
    input  i_step, i_alu_address, i_data_to_write, i_mem_write, i_mem_read,
           i_size_type, i_debug_address,
    output o_alu_address_data, o_debug_address_data, o_misaligned, o_busy
  );

endinterface

// File: rtl/memory_data_sized_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or
// zero-extends it to NB bits; word-sized (and reserved) codes pass through.
module mem_load_extend
  import memory_pkg::*;
#(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3
) (
  input  logic [NB-1:0]           i_word,
  input  logic [1:0]              i_lane,
  input  logic [NB_SIZE_TYPE-1:0] i_size_type,
  output logic [NB-1:0]           o_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        fill_s;

  // Lane selection and extension of the selected lane(s)
  always_comb begin
    fill_s = 1'b0;
    o_data = i_word;
    case (i_lane)
      2'b00:   byte_s = i_word[7:0];
      2'b01:   byte_s = i_word[15:8];
      2'b10:   byte_s = i_word[23:16];
      default: byte_s = i_word[31:24];
    endcase
    half_s = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_size_type[1:0])
      SIZE_BYTE: begin
        fill_s = ~i_size_type[SIZE_UNSIGNED_BIT] & byte_s[7];
        o_data = {{(NB-8){fill_s}}, byte_s};
      end
      SIZE_HALF: begin
        fill_s = ~i_size_type[SIZE_UNSIGNED_BIT] & half_s[15];
        o_data = {{(NB-16){fill_s}}, half_s};
      end
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/memory_data_sized.sv
// MEM-stage data memory with byte/half/word loads and stores, misalignment
// suppression, a post-reset clear sweep and a combinational debug port.
module memory_data_sized
  import memory_pkg::*;
#(
  parameter int NB           = 32,
  parameter int TAM          = 64,
  parameter int NB_SIZE_TYPE = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  memory_data_sized_if.slave bus
);

  localparam int NB_SEL = $clog2(TAM);
  localparam logic [NB_SEL-1:0] CNT_LAST = NB_SEL'(TAM - 1);
  localparam logic [NB_SEL-1:0] CNT_ONE  = NB_SEL'(1);

  logic [NB-1:0]     mem_r [TAM];
  mem_state_e        state_r;
  mem_state_e        state_next_s;
  logic [NB_SEL-1:0] clr_cnt_r;
  logic [NB-1:0]     alu_data_r;
  logic              misaligned_r;
  logic              busy_r;

  logic [NB_SEL-1:0] idx_s;
  logic [NB_SEL-1:0] dbg_idx_s;
  logic [1:0]        lane_s;
  logic [1:0]        size_s;
  logic              mis_s;
  logic              stepped_s;
  logic              store_s;
  logic              load_s;
  logic [3:0]        lane_we_s;
  logic [NB-1:0]     rd_word_s;
  logic [NB-1:0]     wr_word_s;
  logic [NB-1:0]     ld_ext_s;
  logic              unused_addr_bits_s;

  // Address decode, misalignment check and merged store word
  always_comb begin
    idx_s     = bus.i_alu_address[NB_SEL+1:2];
    dbg_idx_s = bus.i_debug_address[NB_SEL+1:2];
    lane_s    = bus.i_alu_address[1:0];
    size_s    = bus.i_size_type[1:0];
    rd_word_s = mem_r[idx_s];
    stepped_s = (state_r == ST_READY) && bus.i_step;
    case (size_s)
      SIZE_BYTE: begin
        mis_s     = 1'b0;
        lane_we_s = 4'b0001 << lane_s;
      end
      SIZE_HALF: begin
        mis_s     = lane_s[0];
        lane_we_s = lane_s[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        mis_s     = (lane_s != 2'b00);
        lane_we_s = 4'b1111;
      end
    endcase
    store_s   = stepped_s && bus.i_mem_write && !mis_s;
    load_s    = stepped_s && bus.i_mem_read && !mis_s;
    wr_word_s = rd_word_s;
    case (size_s)
      SIZE_BYTE: begin
        for (int k = 0; k < 4; k++) begin
          if (lane_we_s[k]) wr_word_s[8*k +: 8] = bus.i_data_to_write[7:0];
          else              wr_word_s[8*k +: 8] = rd_word_s[8*k +: 8];
        end
      end
      SIZE_HALF: begin
        for (int k = 0; k < 4; k++) begin
          if (lane_we_s[k]) wr_word_s[8*k +: 8] = bus.i_data_to_write[8*(k%2) +: 8];
          else              wr_word_s[8*k +: 8] = rd_word_s[8*k +: 8];
        end
      end
      default: wr_word_s = bus.i_data_to_write;
    endcase
  end

  // Upper address bits wrap; they are deliberately ignored
  assign unused_addr_bits_s = ^{bus.i_alu_address[NB-1:NB_SEL+2],
                                bus.i_debug_address[NB-1:NB_SEL+2],
                                bus.i_debug_address[1:0]};

  mem_load_extend #(
    .NB           (NB),
    .NB_SIZE_TYPE (NB_SIZE_TYPE)
  ) u_load_extend (
    .i_word      (rd_word_s),
    .i_lane      (lane_s),
    .i_size_type (bus.i_size_type),
    .o_data      (ld_ext_s)
  );

  // State register: reset always restarts the clear sweep
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_r <= ST_CLEAR;
    else          state_r <= state_next_s;
  end

  // Next state: leave CLEAR after the last word is swept, READY is terminal
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == CNT_LAST) state_next_s = ST_READY;
        else                       state_next_s = ST_CLEAR;
      end
      ST_READY: state_next_s = ST_READY;
      default:  state_next_s = ST_CLEAR;
    endcase
  end

  // Sweep counter advances every clock while clearing
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                  clr_cnt_r <= '0;
    else if (state_r == ST_CLEAR)  clr_cnt_r <= clr_cnt_r + CNT_ONE;
    else                           clr_cnt_r <= clr_cnt_r;
  end

  // Storage: clear sweep writes zero, otherwise aligned stepped stores
  always_ff @(posedge i_clk) begin
    if (state_r == ST_CLEAR) mem_r[clr_cnt_r] <= '0;
    else if (store_s)        mem_r[idx_s]     <= wr_word_s;
  end

  // Registered load result and status flags, updated only on stepped READY clocks
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      busy_r       <= 1'b1;
      alu_data_r   <= '0;
      misaligned_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_CLEAR);
      if (stepped_s) begin
        alu_data_r   <= load_s ? ld_ext_s : '0;
        misaligned_r <= mis_s && (bus.i_mem_write || bus.i_mem_read);
      end else begin
        alu_data_r   <= alu_data_r;
        misaligned_r <= misaligned_r;
      end
    end
  end

  assign bus.o_alu_address_data   = alu_data_r;
  assign bus.o_misaligned         = misaligned_r;
  assign bus.o_busy               = busy_r;
  assign bus.o_debug_address_data = mem_r[dbg_idx_s];

endmodule

// File: tb/tb_memory_data_sized.sv
// Scoreboard bench for memory_data_sized: stepped accesses push their
// expected {misaligned, data} and a monitor checks them after each stepped edge.
module tb_memory_data_sized;

  localparam int NB           = 32;
  localparam int TAM          = 64;
  localparam int NB_SIZE_TYPE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_data_sized_if #(.NB(NB), .NB_SIZE_TYPE(NB_SIZE_TYPE)) bus ();

  memory_data_sized #(
    .NB           (NB),
    .TAM          (TAM),
    .NB_SIZE_TYPE (NB_SIZE_TYPE)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  logic [32:0] exp_q [$];
  string       name_q [$];
  logic [32:0] mon_e;
  string       mon_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: each stepped edge produces one response to compare
  always @(posedge clk) begin
    if (bus.i_step === 1'b1) begin
      #1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_response: got %08h expected none", bus.o_alu_address_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check({mon_n, "_data"}, bus.o_alu_address_data, mon_e[31:0]);
        check({mon_n, "_mis"}, {31'b0, bus.o_misaligned}, {31'b0, mon_e[32]});
      end
    end
  end

  task automatic idle();
    bus.i_step          = 1'b0;
    bus.i_mem_write     = 1'b0;
    bus.i_mem_read      = 1'b0;
    bus.i_alu_address   = 32'h0;
    bus.i_data_to_write = 32'h0;
    bus.i_size_type     = 3'b011;
  endtask

  // One stepped access, issued at a negedge; expectation queued for the monitor
  task automatic access(input string name, input logic wr, input logic rd,
                        input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_d,
                        input logic exp_m);
    bus.i_step          = 1'b1;
    bus.i_mem_write     = wr;
    bus.i_mem_read      = rd;
    bus.i_size_type     = sz;
    bus.i_alu_address   = addr;
    bus.i_data_to_write = wdata;
    exp_q.push_back({exp_m, exp_d});
    name_q.push_back(name);
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic dbg_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.i_debug_address = addr;
    #1;
    check(name, bus.o_debug_address_data, exp);
  endtask

  // Release reset at a negedge and count clocks until busy falls
  task automatic sweep_count(input string name);
    int n;
    n = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!bus.o_busy) break;
    end
    check(name, n, 32'd64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.i_debug_address = 32'h0;
    @(negedge clk);
    check("reset_busy", {31'b0, bus.o_busy}, 32'd1);
    check("reset_data", bus.o_alu_address_data, 32'h0);
    check("reset_mis", {31'b0, bus.o_misaligned}, 32'd0);

    sweep_count("sweep_len");
    for (int i = 0; i < TAM; i++) dbg_check("swept_zero", i * 4, 32'h0);

    // Sized stores and loads on word 4
    access("st_word_10",   1'b1, 1'b0, 3'b011, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access("st_byte_11",   1'b1, 1'b0, 3'b000, 32'h11, 32'h0000007F, 32'h0, 1'b0);
    dbg_check("dbg_10", 32'h10, 32'hDEAD7FEF);
    access("ld_word_10",   1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
    access("ld_sbyte_13",  1'b0, 1'b1, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    access("ld_ubyte_13",  1'b0, 1'b1, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    access("ld_shalf_12",  1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    access("ld_uhalf_12",  1'b0, 1'b1, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    access("ld_uhalf_10",  1'b0, 1'b1, 3'b101, 32'h10, 32'h0, 32'h00007FEF, 1'b0);
    access("ld_sbyte_10",  1'b0, 1'b1, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    access("ld_ubyte_11",  1'b0, 1'b1, 3'b100, 32'h11, 32'h0, 32'h0000007F, 1'b0);
    access("ld_rsvd_10",   1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
    access("ld_half_11",   1'b0, 1'b1, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    access("ld_word_12",   1'b0, 1'b1, 3'b011, 32'h12, 32'h0, 32'h0, 1'b1);
    access("st_half_11",   1'b1, 1'b0, 3'b001, 32'h11, 32'h0000AAAA, 32'h0, 1'b1);
    dbg_check("dbg_10_after_mis", 32'h10, 32'hDEAD7FEF);
    access("no_access",    1'b0, 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b0);

    // Unstepped cycles hold outputs and memory
    access("ld_word_10b",  1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
    bus.i_mem_write = 1'b1; bus.i_size_type = 3'b011;
    bus.i_alu_address = 32'h20; bus.i_data_to_write = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk); idle();
    dbg_check("hold_mem_20", 32'h20, 32'h0);
    check("hold_data", bus.o_alu_address_data, 32'hDEAD7FEF);
    access("ld_half_11b",  1'b0, 1'b1, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    bus.i_mem_read = 1'b1; bus.i_size_type = 3'b011; bus.i_alu_address = 32'h10;
    @(posedge clk); @(negedge clk); idle();
    check("hold_mis", {31'b0, bus.o_misaligned}, 32'd1);
    check("hold_data0", bus.o_alu_address_data, 32'h0);
    access("st_word_20",   1'b1, 1'b0, 3'b011, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    dbg_check("dbg_20", 32'h20, 32'hCAFEF00D);

    // Same-cycle read/write returns old data; address aliasing
    access("rw_same_30",   1'b1, 1'b1, 3'b011, 32'h30, 32'h12345678, 32'h0, 1'b0);
    access("ld_alias_130", 1'b0, 1'b1, 3'b011, 32'h130, 32'h0, 32'h12345678, 1'b0);
    dbg_check("dbg_alias_130", 32'h130, 32'h12345678);

    // Reset mid-operation, then again mid-sweep at counter 20
    rst_n = 1'b0;
    #1;
    check("rst_op_data", bus.o_alu_address_data, 32'h0);
    check("rst_op_busy", {31'b0, bus.o_busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("mid_sweep_busy", {31'b0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, bus.o_busy}, 32'd1);
    @(negedge clk);
    sweep_count("resweep_len");
    dbg_check("reswept_10", 32'h10, 32'h0);
    dbg_check("reswept_30", 32'h30, 32'h0);
    access("ld_after_reswp", 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
